// File: rtl/ex_stage.sv
// Execute stage: ALU ops plus an iterative shift-add multiply, registered into the EX/MEM boundary.
// Latency: 1 edge for single-cycle ops; MUL result appears DATA_W+1 edges after its launch edge.
// Backpressure: stall holds ID/EX and earlier stages while a multiply launches or is busy; flush squashes.
// Optional operand forwarding (EX/MEM result and writeback bypass) is enabled by defining EX_FWD_EN.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int IMM_W  = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        ex_ctrl,
    input  logic [6:0]        mem_ctrl,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [RD_W-1:0]   rd_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              flush,
`ifdef EX_FWD_EN
    input  logic [RD_W-1:0]   rs_a,
    input  logic [RD_W-1:0]   rs_b,
    input  logic [RD_W-1:0]   wb_rd,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store,
    output logic [RD_W-1:0]   out_rd,
    output logic [6:0]        out_mem,
    output logic              out_zero,
    output logic              out_neg
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] opa_raw;
    logic [DATA_W-1:0] opb_raw;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        op;
    logic              alu_src;
    logic              is_mul;
    logic              launch;
    logic              single;

    // Multiply working state, captured at launch so held upstream inputs are ignored
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;
    logic [DATA_W-1:0] mul_store;
    logic [RD_W-1:0]   mul_rd;
    logic [6:0]        mul_mem;
    logic [CNT_W-1:0]  mul_cnt;

    assign op      = ex_ctrl[2:0];
    assign alu_src = ex_ctrl[3];
    assign is_mul  = (op == OP_MUL);
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef EX_FWD_EN
    // Operand bypass: own registered result beats writeback; register 0 is never forwarded
    always_comb begin
        opa_raw = rd1;
        opb_raw = rd2;
        if (out_valid && (out_rd == rs_a) && (out_rd != '0)) begin
            opa_raw = out_alu;
        end else if (wb_we && (wb_rd == rs_a) && (wb_rd != '0)) begin
            opa_raw = wb_data;
        end
        if (out_valid && (out_rd == rs_b) && (out_rd != '0)) begin
            opb_raw = out_alu;
        end else if (wb_we && (wb_rd == rs_b) && (wb_rd != '0)) begin
            opb_raw = wb_data;
        end
    end
`else
    assign opa_raw = rd1;
    assign opb_raw = rd2;
`endif

    assign opb = alu_src ? imm_ext : opb_raw;

    // Single-cycle ALU; MUL is handled by the iterative datapath
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = opa_raw + opb;
            OP_SUB:   alu_res = opa_raw - opb;
            OP_AND:   alu_res = opa_raw & opb;
            OP_OR:    alu_res = opa_raw | opb;
            OP_XOR:   alu_res = opa_raw ^ opb;
            OP_PASSB: alu_res = opb;
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_raw) < $signed(opb))};
            default:  alu_res = '0;
        endcase
    end

    assign launch = (state_q == IDLE) && in_valid && is_mul && !flush;
    assign single = (state_q == IDLE) && in_valid && !is_mul && !flush;

    // Stall covers the launch cycle and every BUSY cycle; DONE lets upstream advance
    assign stall = rst_n && (((state_q == IDLE) && in_valid && is_mul) || (state_q == BUSY));

    // FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush aborts anything in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = BUSY;
            BUSY: if (mul_cnt == CNT_W'(DATA_W - 1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: EX/MEM outputs and multiply shift-add steps
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_alu    <= '0;
            out_store  <= '0;
            out_rd     <= '0;
            out_mem    <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_store  <= '0;
            mul_rd     <= '0;
            mul_mem    <= '0;
            mul_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (single) begin
                        out_valid <= 1'b1;
                        out_alu   <= alu_res;
                        out_store <= opb_raw;
                        out_rd    <= rd_addr;
                        out_mem   <= mem_ctrl;
                        out_zero  <= (alu_res == '0);
                        out_neg   <= alu_res[DATA_W-1];
                    end else begin
                        out_valid <= 1'b0;
                    end
                    if (launch) begin
                        mul_acc    <= '0;
                        mul_mcand  <= opa_raw;
                        mul_mplier <= opb;
                        mul_store  <= opb_raw;
                        mul_rd     <= rd_addr;
                        mul_mem    <= mem_ctrl;
                        mul_cnt    <= '0;
                    end
                end
                BUSY: begin
                    out_valid  <= 1'b0;
                    if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + CNT_W'(1);
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_alu   <= mul_acc;
                    out_store <= mul_store;
                    out_rd    <= mul_rd;
                    out_mem   <= mul_mem;
                    out_zero  <= (mul_acc == '0);
                    out_neg   <= mul_acc[DATA_W-1];
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: scoreboard of expected EX/MEM results plus per-scenario inline checks.
// Inputs are driven and outputs sampled on the falling clock edge.
// Forwarding scenarios are compiled in only when EX_FWD_EN is defined.
module tb_ex_stage;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  ex_ctrl;
    logic [6:0]  mem_ctrl;
    logic [31:0] rd1, rd2;
    logic [5:0]  rd_addr;
    logic [15:0] imm;
    logic        flush;
    logic        stall, out_valid, out_zero, out_neg;
    logic [31:0] out_alu, out_store;
    logic [5:0]  out_rd;
    logic [6:0]  out_mem;
`ifdef EX_FWD_EN
    logic [5:0]  rs_a = '0, rs_b = '0, wb_rd = '0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_data = '0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [5:0]  rd;
        logic [6:0]  mem;
    } exp_t;
    exp_t sbq[$];

    always #5 clock = ~clock;

    ex_stage dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .rd1(rd1), .rd2(rd2), .rd_addr(rd_addr), .imm(imm),
        .flush(flush),
`ifdef EX_FWD_EN
        .rs_a(rs_a), .rs_b(rs_b), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
`endif
        .stall(stall), .out_valid(out_valid), .out_alu(out_alu), .out_store(out_store),
        .out_rd(out_rd), .out_mem(out_mem), .out_zero(out_zero), .out_neg(out_neg)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return b;
            3'd6: return a * b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Scoreboard: every valid EX/MEM slot must match the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (rst_n && out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid alu=%h rd=%0d with empty scoreboard", out_alu, out_rd);
            end else begin
                e = sbq.pop_front();
                if (out_alu !== e.alu || out_store !== e.store || out_rd !== e.rd ||
                    out_mem !== e.mem || out_zero !== (e.alu == 32'd0) || out_neg !== e.alu[31]) begin
                    errors++;
                    $display("FAIL result got alu=%h store=%h rd=%0d mem=%h z=%b n=%b expected alu=%h store=%h rd=%0d mem=%h",
                             out_alu, out_store, out_rd, out_mem, out_zero, out_neg, e.alu, e.store, e.rd, e.mem);
                end
            end
        end
    end

    // Present one instruction for one cycle; ea/eb are the operands the bench expects the DUT to use
    task automatic issue_x(input logic [2:0] op, input logic src, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] im, input logic [5:0] rd, input logic [6:0] mem,
                           input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        logic [31:0] bop;
        in_valid = 1'b1; ex_ctrl = {src, op}; rd1 = a; rd2 = b; imm = im; rd_addr = rd; mem_ctrl = mem;
        bop = src ? {{16{im[15]}}, im} : eb;
        e.alu = model(op, ea, bop); e.store = eb; e.rd = rd; e.mem = mem;
        sbq.push_back(e);
        @(negedge clock);
    endtask

    task automatic issue(input logic [2:0] op, input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic [5:0] rd, input logic [6:0] mem);
        issue_x(op, src, a, b, im, rd, mem, a, b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; ex_ctrl = 4'b0110;
        rd1 = 32'h1234; rd2 = 32'h5678; rd_addr = 6'd9; imm = 16'h0; mem_ctrl = 7'h7f;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_valid, out_alu, out_store, out_rd, out_mem, out_zero, out_neg} !== '0) begin
            errors++; $display("FAIL reset_outputs got valid=%b alu=%h store=%h rd=%0d mem=%h z=%b n=%b required all 0",
                               out_valid, out_alu, out_store, out_rd, out_mem, out_zero, out_neg);
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b required 0", stall); end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        issue(3'd0, 1'b0, 32'd5, 32'd7, 16'h0, 6'd3, 7'h11);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'd12) begin
            errors++; $display("FAIL first_add got valid=%b alu=%h required 1 0000000c", out_valid, out_alu);
        end
        // Launch a multiply and reset in the middle of it
        in_valid = 1'b1; ex_ctrl = 4'b0110; rd1 = 32'd3; rd2 = 32'd4;
        repeat (5) @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_alu, out_store, out_rd, out_mem, out_zero, out_neg, stall} !== '0) begin
            errors++; $display("FAIL midmul_reset got valid=%b alu=%h stall=%b required all 0", out_valid, out_alu, stall);
        end
        in_valid = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        issue(3'd1, 1'b0, 32'd20, 32'd8, 16'h0, 6'd4, 7'h01);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'd12) begin
            errors++; $display("FAIL post_reset_idle got valid=%b alu=%h required 1 0000000c", out_valid, out_alu);
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_imm();
        issue(3'd0, 1'b1, 32'd3, 32'hDEAD_BEEF, 16'hFFFF, 6'd7, 7'h22);
        checks++;
        if (out_alu !== 32'd2 || out_store !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL imm_add got alu=%h store=%h required 00000002 deadbeef", out_alu, out_store);
        end
        issue(3'd1, 1'b0, 32'd0, 32'd1, 16'h0, 6'd8, 7'h23);
        checks++;
        if (out_alu !== 32'hFFFF_FFFF || out_neg !== 1'b1 || out_zero !== 1'b0) begin
            errors++; $display("FAIL sub_neg got alu=%h n=%b z=%b required ffffffff 1 0", out_alu, out_neg, out_zero);
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_slt();
        issue(3'd7, 1'b0, -32'sd4, 32'd2, 16'h0, 6'd10, 7'h03);
        checks++;
        if (out_alu !== 32'd1) begin errors++; $display("FAIL slt_true got %h required 00000001", out_alu); end
        issue(3'd7, 1'b0, 32'd2, -32'sd4, 16'h0, 6'd11, 7'h04);
        checks++;
        if (out_alu !== 32'd0 || out_zero !== 1'b1) begin
            errors++; $display("FAIL slt_false got alu=%h z=%b required 00000000 1", out_alu, out_zero);
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [2:0] op;
            op = 3'(i % 6);
            issue(op, i[0], $urandom, $urandom, 16'($urandom), 6'($urandom_range(1, 63)), 7'($urandom));
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mul();
        exp_t e;
        int bad;
        in_valid = 1'b1; ex_ctrl = 4'b0110; rd1 = 32'h0001_0003; rd2 = 32'h0001_0002;
        rd_addr = 6'd12; mem_ctrl = 7'h35; imm = 16'h0;
        e.alu = model(3'd6, 32'h0001_0003, 32'h0001_0002); e.store = 32'h0001_0002; e.rd = 6'd12; e.mem = 7'h35;
        sbq.push_back(e);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL mul_launch_stall got %b required 1", stall); end
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clock);
            rd1 = $urandom; rd2 = $urandom; rd_addr = 6'd63; mem_ctrl = 7'h00;
            #1;
            if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mul_busy_window got %0d bad cycles required 0", bad); end
        @(negedge clock);
        checks++;
        if (stall !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_done_cycle got stall=%b valid=%b required 0 0", stall, out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'h0005_0006) begin
            errors++; $display("FAIL mul_product got valid=%b alu=%h required 1 00050006", out_valid, out_alu);
        end
        issue(3'd0, 1'b0, 32'd100, 32'd23, 16'h0, 6'd13, 7'h36);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'd123) begin
            errors++; $display("FAIL add_after_mul got valid=%b alu=%h required 1 0000007b", out_valid, out_alu);
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_flush();
        int seen;
        in_valid = 1'b1; ex_ctrl = 4'b0110; rd1 = 32'd7; rd2 = 32'd9; rd_addr = 6'd14; mem_ctrl = 7'h40;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_mul got stall=%b valid=%b required 0 0", stall, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_product got %0d valid cycles required 0", seen); end
        issue(3'd4, 1'b0, 32'hF0F0_0000, 32'h0FF0_FFFF, 16'h0, 6'd15, 7'h41);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'hFF00_FFFF) begin
            errors++; $display("FAIL after_flush got valid=%b alu=%h required 1 ff00ffff", out_valid, out_alu);
        end
        // Flush and MUL launch on the same edge: no launch
        ex_ctrl = 4'b0110; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        issue(3'd0, 1'b0, 32'd1, 32'd2, 16'h0, 6'd16, 7'h42);
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'd3) begin
            errors++; $display("FAIL flush_vs_launch got valid=%b alu=%h required 1 00000003", out_valid, out_alu);
        end
        // Flushed single-cycle op produces a bubble
        ex_ctrl = 4'b0000; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_single got valid=%b required 0", out_valid); end
        @(negedge clock);
    endtask

`ifdef EX_FWD_EN
    task automatic test_fwd();
        rs_a = 6'd1; rs_b = 6'd2;
        issue_x(3'd0, 1'b0, 32'd1, 32'd1, 16'h0, 6'd5, 7'h50, 32'd1, 32'd1);
        rs_a = 6'd5; rs_b = 6'd5;
        issue_x(3'd0, 1'b0, 32'd99, 32'd99, 16'h0, 6'd6, 7'h51, 32'd2, 32'd2);
        checks++;
        if (out_alu !== 32'd4) begin errors++; $display("FAIL fwd_exmem got %h required 00000004", out_alu); end
        rs_a = 6'd1; rs_b = 6'd2;
        issue_x(3'd0, 1'b0, 32'd1, 32'd1, 16'h0, 6'd5, 7'h52, 32'd1, 32'd1);
        wb_we = 1'b1; wb_rd = 6'd5; wb_data = 32'd100; rs_a = 6'd5; rs_b = 6'd5;
        issue_x(3'd0, 1'b0, 32'd99, 32'd99, 16'h0, 6'd6, 7'h53, 32'd2, 32'd2);
        checks++;
        if (out_alu !== 32'd4) begin errors++; $display("FAIL fwd_priority got %h required 00000004", out_alu); end
        in_valid = 1'b0;
        @(negedge clock);
        rs_b = 6'd0;
        issue_x(3'd0, 1'b0, 32'd9, 32'd7, 16'h0, 6'd7, 7'h54, 32'd100, 32'd7);
        checks++;
        if (out_alu !== 32'd107) begin errors++; $display("FAIL fwd_wb got %h required 0000006b", out_alu); end
        wb_rd = 6'd0; wb_data = 32'd50; rs_a = 6'd3; rs_b = 6'd4;
        issue_x(3'd0, 1'b0, 32'd10, 32'd10, 16'h0, 6'd0, 7'h55, 32'd10, 32'd10);
        rs_a = 6'd0; rs_b = 6'd0;
        issue_x(3'd0, 1'b0, 32'd1, 32'd2, 16'h0, 6'd8, 7'h56, 32'd1, 32'd2);
        checks++;
        if (out_alu !== 32'd3) begin errors++; $display("FAIL fwd_r0 got %h required 00000003", out_alu); end
        in_valid = 1'b0; wb_we = 1'b0;
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_imm();
        test_slt();
        test_back_to_back();
        test_mul();
        test_flush();
`ifdef EX_FWD_EN
        test_fwd();
`endif
        repeat (2) @(negedge clock);
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It sits directly downstream of the ID/EX pipeline buffer and consumes that buffer's outputs: EX control, MEM control, RD1, RD2, destination register and 16-bit immediate.
- It performs the ALU operation, including an iterative multi-cycle multiply, and registers results into the EX/MEM boundary.
- During a multiply it stalls upstream stages.

Parameters:
- DATA_W, 32, operand/result width.
- RD_W, 6, destination register address width.
- IMM_W, 16, immediate width; sign-extended to DATA_W.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX slot holds a real instruction.
- ex_ctrl  in  4  bit3 = alu_src (1: operand B = sext(imm)); bits2:0 = op.
- mem_ctrl  in  7  MEM control, passed through.
- rd1  in  DATA_W  operand A.
- rd2  in  DATA_W  operand B / store data.
- rd_addr  in  RD_W  destination register.
- imm  in  IMM_W  immediate.
- flush  in  1  synchronous squash (branch taken).
- stall  out  1  hold ID/EX and earlier stages.
- out_valid  out  1  EX/MEM slot valid.
- out_alu  out  DATA_W  result.
- out_store  out  DATA_W  store data (operand B before the imm mux).
- out_rd  out  RD_W  destination register.
- out_mem  out  7  MEM control.
- out_zero  out  1  out_alu == 0.
- out_neg  out  1  out_alu[DATA_W-1].

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - FSM is in IDLE; multiply counter and accumulators are 0.
- Op codes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 MUL, 111 SLT (signed, result 1 or 0).
  - Arithmetic wraps modulo 2^DATA_W.
  - MUL returns the low DATA_W bits of the product.
- Single-cycle ops:
  - On the edge where in_valid=1, stall=0 and flush=0, register out_alu/out_store/out_rd/out_mem/flags and set out_valid=1.
  - Latency is 1 edge.
- Bubbles:
  - If in_valid=0 or stall=1, set out_valid<=0.
  - Data outputs hold their previous values.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: in_valid & op==MUL & !flush. On this launch edge: capture A/B, rd_addr, mem_ctrl; count=0; out_valid<=0.
  - BUSY: each edge performs one shift-add step and count++. When count reaches DATA_W, go to DONE.
  - DONE: stall=0. On the next edge, write the product to out_alu, set out_valid=1, return to IDLE. Upstream advances on that same edge, so the held MUL is not relaunched.
  - MUL result is visible after launch edge + DATA_W + 1 edges.
- stall (combinational) = (IDLE & in_valid & op==MUL) | BUSY.
- Inputs held during stall are ignored; the captured copies are used.
- flush:
  - Takes priority over everything except reset.
  - out_valid<=0 and FSM goes to IDLE (an in-flight multiply is aborted).
  - stall drops in the cycle after the flush edge.
  - flush and launch on the same edge: flush wins and no launch occurs.
- rst_n asserted mid-multiply: immediate return to IDLE, stall=0.
- out_zero and out_neg always reflect the registered out_alu.

Optional Feature:
- Macro: EX_FWD_EN.
- When defined, adds ports:
  - rs_a in RD_W, rs_b in RD_W: source register addresses.
  - wb_rd in RD_W, wb_we in 1, wb_data in DATA_W: writeback bypass.
- Operand A and operand B (pre-imm mux, also used for out_store) are forwarded with this priority:
  1. This stage's own registered result, when out_valid & out_rd==rs & out_rd!=0.
  2. Writeback, when wb_we & wb_rd==rs & wb_rd!=0.
  3. Otherwise rd1/rd2.
- Forwarding is applied at the launch edge for MUL.
- When not defined, these ports are absent and rd1/rd2 are used directly.

Test Plan:
- Reset: drive rst_n=0 mid-stream → all outputs 0, stall=0. Release → first ADD of 5+7 gives out_alu=12, out_valid=1 one edge later.
- Immediate path: alu_src=1, imm=16'hFFFF, rd1=3, ADD → out_alu=2. SUB with 0-1 → out_alu=32'hFFFFFFFF, out_neg=1, out_zero=0.
- Multiply: rd1=32'h0001_0003, rd2=32'h0001_0002 →
  - stall high from the launch cycle through BUSY (33 cycles with DATA_W=32);
  - out_valid stays 0 during this period;
  - on the edge after that, out_alu=32'h0005_0006, out_valid=1;
  - the next queued ADD completes on the following edge.
- Flush mid-multiply: assert flush on BUSY cycle 10 → out_valid=0, stall=0 next cycle, no product is ever written, the following instruction executes normally.
- SLT and zero flag: rd1=-4, rd2=2 → out_alu=1. Swapped operands → out_alu=0, out_zero=1.
- EX_FWD_EN build:
  - back-to-back ADD r5=1+1 then ADD r6=r5+r5 → 4;
  - with wb_rd=5 also hitting, EX/MEM wins;
  - rs=0 is never forwarded.
